// File: rtl/sem_mailbox_pkg.sv
// Shared constants and control-state encoding for the semaphore mailbox.
// Word width matches the CPU data path width of 1.
package sem_mailbox_pkg;

  localparam int SEM_DATA_WIDTH = 1;
  localparam int SEM_DEPTH     = 8;
  localparam int SEM_PTR_WIDTH = 3;

  typedef enum logic [1:0] {
    SEM_ST_EMPTY   = 2'd0,
    SEM_ST_PARTIAL = 2'd1,
    SEM_ST_FULL    = 2'd2
  } sem_state_t;

endpackage

// File: rtl/sem_mailbox_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately left unreset; validity is tracked by the owner.
module sem_mailbox_mem #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sem_mailbox.sv
// First-word-fall-through mailbox between a writer CPU and a reader CPU.
// Define SEM_MAILBOX_ERR_EN to add sticky overflow/underflow flags with clear.
module sem_mailbox
  import sem_mailbox_pkg::*;
#(
  parameter int DATA_WIDTH = SEM_DATA_WIDTH,
  parameter int DEPTH      = SEM_DEPTH,
  parameter int PTR_WIDTH  = SEM_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  wr_valid_in,
  output logic                  wr_empty_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  input  logic                  rd_read_in,
  output logic [PTR_WIDTH:0]    level_out
`ifdef SEM_MAILBOX_ERR_EN
  ,
  input  logic                  err_clr_in,
  output logic                  overflow_out,
  output logic                  underflow_out
`endif
);

  localparam logic [PTR_WIDTH:0]   COUNT_FULL = DEPTH;
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = 1;

  logic [PTR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_WIDTH:0]    count_reg, count_next;
  sem_state_t            state_reg, state_next;
  logic                  rd_pop, wr_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign rd_pop    = rd_read_in && (state_reg != SEM_ST_EMPTY);
  // A pop in the same cycle frees the slot, so a full mailbox still accepts.
  assign wr_accept = wr_valid_in && ((state_reg != SEM_ST_FULL) || rd_pop);

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_pop)      count_next = count_reg + COUNT_ONE;
    else if (rd_pop && !wr_accept) count_next = count_reg - COUNT_ONE;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEM_ST_EMPTY:   if (wr_accept) state_next = (count_next == COUNT_FULL) ? SEM_ST_FULL : SEM_ST_PARTIAL;
      SEM_ST_PARTIAL: begin
        if (count_next == '0)              state_next = SEM_ST_EMPTY;
        else if (count_next == COUNT_FULL) state_next = SEM_ST_FULL;
      end
      SEM_ST_FULL:    if (count_next != COUNT_FULL) state_next = (count_next == '0) ? SEM_ST_EMPTY : SEM_ST_PARTIAL;
      default:        state_next = SEM_ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= SEM_ST_EMPTY;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_pop)    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      state_reg <= state_next;
    end
  end

  sem_mailbox_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_reg),
    .wdata (wr_data_in),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign rd_valid_out = (state_reg != SEM_ST_EMPTY);
  assign wr_empty_out = (state_reg != SEM_ST_FULL);
  assign level_out    = count_reg;
  // Unwritten slots may hold stale data, so the head is masked when empty.
  assign rd_data_out  = rd_valid_out ? mem_rdata : '0;

`ifdef SEM_MAILBOX_ERR_EN
  logic overflow_reg, underflow_reg;
  logic overflow_set, underflow_set;

  assign overflow_set  = wr_valid_in && (state_reg == SEM_ST_FULL) && !rd_pop;
  assign underflow_set = rd_read_in && (state_reg == SEM_ST_EMPTY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (overflow_set)    overflow_reg <= 1'b1;
      else if (err_clr_in) overflow_reg <= 1'b0;
      if (underflow_set)   underflow_reg <= 1'b1;
      else if (err_clr_in) underflow_reg <= 1'b0;
    end
  end

  assign overflow_out  = overflow_reg;
  assign underflow_out = underflow_reg;
`endif

endmodule
